// File: rtl/gpu_instruction_buffer_pkg.sv
// Shared widths and the packed draw-instruction entry for the instruction buffer.
// Field order in instr_t is the storage packing order, MSB first.
package gpu_instruction_buffer_pkg;

    localparam int unsigned OPCODE_BITS          = 4;
    localparam int unsigned WIDTH_BITS           = 10;
    localparam int unsigned HEIGHT_BITS          = 9;
    localparam int unsigned CHANNEL_BITS         = 8;
    localparam int unsigned GPU_INSTR_FIFO_DEPTH = 8;
    localparam int unsigned GPU_INSTR_W          = OPCODE_BITS + 3 * WIDTH_BITS
                                                 + 2 * HEIGHT_BITS + 3 * CHANNEL_BITS;

    typedef struct packed {
        logic [OPCODE_BITS-1:0]  opcode;
        logic [WIDTH_BITS-1:0]   x1;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [WIDTH_BITS-1:0]   rad;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
    } instr_t;

endpackage

// File: rtl/gpu_instr_fifo_mem.sv
// Instruction storage array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module gpu_instr_fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gpu_instruction_buffer.sv
// Show-ahead FIFO of draw instructions between the decoder and the rasterizer,
// with a sticky overflow flag for pushes dropped while full.
module gpu_instruction_buffer
    import gpu_instruction_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = GPU_INSTR_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [OPCODE_BITS-1:0]    opcode_i,
    input  logic [WIDTH_BITS-1:0]     x1_i,
    input  logic [HEIGHT_BITS-1:0]    y1_i,
    input  logic [WIDTH_BITS-1:0]     x2_i,
    input  logic [HEIGHT_BITS-1:0]    y2_i,
    input  logic [WIDTH_BITS-1:0]     rad_i,
    input  logic [CHANNEL_BITS-1:0]   r_i,
    input  logic [CHANNEL_BITS-1:0]   g_i,
    input  logic [CHANNEL_BITS-1:0]   b_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [OPCODE_BITS-1:0]    opcode_o,
    output logic [WIDTH_BITS-1:0]     x1_o,
    output logic [HEIGHT_BITS-1:0]    y1_o,
    output logic [WIDTH_BITS-1:0]     x2_o,
    output logic [HEIGHT_BITS-1:0]    y2_o,
    output logic [WIDTH_BITS-1:0]     rad_o,
    output logic [CHANNEL_BITS-1:0]   r_o,
    output logic [CHANNEL_BITS-1:0]   g_o,
    output logic [CHANNEL_BITS-1:0]   b_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      overflow_o,
    input  logic                      clear_ovf_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic   full_c;
    logic   pop_c;
    logic   push_ok_c;
    logic   drop_c;
    instr_t wentry_c;
    instr_t head_c;
    logic [GPU_INSTR_W-1:0] rdata_c;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push alongside it.
    always_comb begin
        full_c    = (count_q == CNT_W'(DEPTH));
        pop_c     = (count_q != '0) && instr_ready_i;
        push_ok_c = push_i && (!full_c || pop_c);
        drop_c    = push_i && full_c && !pop_c;
    end

    always_comb begin
        wentry_c = '{opcode: opcode_i, x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i,
                     rad: rad_i, r: r_i, g: g_i, b: b_i};
    end

    gpu_instr_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (GPU_INSTR_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_c),
        .waddr (wptr_q),
        .wdata (wentry_c),
        .raddr (rptr_q),
        .rdata (rdata_c)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push_ok_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_ok_c) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head_c        = instr_t'(rdata_c);
    assign instr_valid_o = (count_q != '0);
    assign opcode_o      = head_c.opcode;
    assign x1_o          = head_c.x1;
    assign y1_o          = head_c.y1;
    assign x2_o          = head_c.x2;
    assign y2_o          = head_c.y2;
    assign rad_o         = head_c.rad;
    assign r_o           = head_c.r;
    assign g_o           = head_c.g;
    assign b_o           = head_c.b;
    assign count_o       = count_q;
    assign full_o        = full_c;
    assign empty_o       = (count_q == '0);
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_gpu_instruction_buffer.sv
// Scoreboard bench: a queue-based reference model predicts occupancy/flags and the
// order of entries; a negedge monitor compares the DUT head and status against it.
module tb_gpu_instruction_buffer;
    import gpu_instruction_buffer_pkg::*;

    localparam int unsigned DEPTH = GPU_INSTR_FIFO_DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    logic push_i = 1'b0;
    logic instr_ready_i = 1'b0;
    logic clear_ovf_i = 1'b0;
    instr_t in_e = '0;

    logic                    instr_valid_o;
    logic [OPCODE_BITS-1:0]  opcode_o;
    logic [WIDTH_BITS-1:0]   x1_o, x2_o, rad_o;
    logic [HEIGHT_BITS-1:0]  y1_o, y2_o;
    logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
    logic [CNT_W-1:0]        count_o;
    logic                    full_o, empty_o, overflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    instr_t exp_q[$];
    int     m_count = 0;
    logic   m_ovf = 1'b0;

    always #5 tb_clk = ~tb_clk;

    gpu_instruction_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (tb_clk),
        .rst           (rst),
        .push_i        (push_i),
        .opcode_i      (in_e.opcode),
        .x1_i          (in_e.x1),
        .y1_i          (in_e.y1),
        .x2_i          (in_e.x2),
        .y2_i          (in_e.y2),
        .rad_i         (in_e.rad),
        .r_i           (in_e.r),
        .g_i           (in_e.g),
        .b_i           (in_e.b),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .opcode_o      (opcode_o),
        .x1_o          (x1_o),
        .y1_o          (y1_o),
        .x2_o          (x2_o),
        .y2_o          (y2_o),
        .rad_o         (rad_o),
        .r_o           (r_o),
        .g_o           (g_o),
        .b_o           (b_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o),
        .clear_ovf_i   (clear_ovf_i)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a FIFO of at most DEPTH entries; a full FIFO takes a push only if it pops too.
    always @(posedge tb_clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            automatic bit pop = (m_count > 0) && instr_ready_i;
            automatic bit acc = push_i && ((m_count < DEPTH) || pop);
            automatic bit drp = push_i && !acc;
            if (acc) exp_q.push_back(in_e);
            m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (drp) m_ovf = 1'b1;
            else if (clear_ovf_i) m_ovf = 1'b0;
        end
    end

    // Monitor: status every cycle; head while valid; dequeue expected entry on handshake.
    always @(negedge tb_clk) begin
        check("valid", 128'(instr_valid_o), 128'(m_count != 0));
        check("count", 128'(count_o), 128'(m_count));
        check("full", 128'(full_o), 128'(m_count == DEPTH));
        check("empty", 128'(empty_o), 128'(m_count == 0));
        check("overflow", 128'(overflow_o), 128'(m_ovf));
        if (instr_valid_o) begin
            if (exp_q.size() == 0) begin
                check("head_expected", 128'(1), 128'(0));
            end else begin
                automatic instr_t got = '{opcode: opcode_o, x1: x1_o, y1: y1_o, x2: x2_o,
                                          y2: y2_o, rad: rad_o, r: r_o, g: g_o, b: b_o};
                check("head", 128'(got), 128'(exp_q[0]));
                if (instr_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic p, input logic rd, input logic clr, input instr_t e);
        push_i        = p;
        instr_ready_i = rd;
        clear_ovf_i   = clr;
        in_e          = e;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    function automatic instr_t rand_entry();
        instr_t e;
        e.opcode = OPCODE_BITS'($urandom);
        e.x1     = WIDTH_BITS'($urandom);
        e.y1     = HEIGHT_BITS'($urandom);
        e.x2     = WIDTH_BITS'($urandom);
        e.y2     = HEIGHT_BITS'($urandom);
        e.rad    = WIDTH_BITS'($urandom);
        e.r      = CHANNEL_BITS'($urandom);
        e.g      = CHANNEL_BITS'($urandom);
        e.b      = CHANNEL_BITS'($urandom);
        return e;
    endfunction

    function automatic instr_t x1_entry(input int i);
        instr_t e = rand_entry();
        e.x1 = WIDTH_BITS'(i);
        return e;
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, x1_entry(i));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        instr_t e;
        #22 rst = 1'b0;
        @(posedge tb_clk); #1;

        // Single entry with fixed fields, then one pop
        e = '{opcode: 4'd4, x1: '0, y1: '0, x2: WIDTH_BITS'(7), y2: HEIGHT_BITS'(6),
              rad: '0, r: '1, g: '1, b: '1};
        cycle(1'b1, 1'b0, 1'b0, e);
        check("first_valid", 128'(instr_valid_o), 128'(1));
        check("first_x2", 128'(x2_o), 128'(7));
        drain(1);
        idle(1);

        // Fill to full, then drain in order
        fill(8);
        idle(1);
        drain(8);
        idle(1);

        // Drop on full, head unchanged, then clear the sticky flag
        fill(8);
        cycle(1'b1, 1'b0, 1'b0, x1_entry(99));
        idle(1);
        check("drop_head_x1", 128'(x1_o), 128'(0));
        cycle(1'b0, 1'b0, 1'b1, '0);
        idle(1);

        // Push and pop together while full
        cycle(1'b1, 1'b1, 1'b0, x1_entry(55));
        drain(8);
        idle(1);

        // Pointer wrap
        fill(5);
        drain(5);
        fill(6);
        drain(6);
        idle(1);

        // Asynchronous reset mid-cycle with three entries and overflow set
        fill(8);
        cycle(1'b1, 1'b0, 1'b0, x1_entry(77));
        drain(5);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 128'(instr_valid_o), 128'(0));
        check("arst_count", 128'(count_o), 128'(0));
        check("arst_ovf", 128'(overflow_o), 128'(0));
        check("arst_empty", 128'(empty_o), 128'(1));
        @(negedge tb_clk);
        #2 rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, x1_entry(3));
        drain(1);
        idle(1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), rand_entry());
        end
        drain(DEPTH + 1);
        idle(1);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        check("final_count", 128'(count_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
